// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forwarding select
// encodings and the halt/drain FSM state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hs_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit bundle. master = pipeline (drives stage
// info, consumes controls); slave = hazard unit.
interface hazard_scoreboard_if #(
    parameter int RAW  = 5,
    parameter int NSRC = 2,
    parameter int SCW  = 32
);
    logic [NSRC*RAW-1:0] src_d;
    logic [NSRC*RAW-1:0] src_e;
    logic [RAW-1:0]      wr_reg_e;
    logic [RAW-1:0]      wr_reg_m;
    logic [RAW-1:0]      wr_reg_w;
    logic                wr_en_e;
    logic                wr_en_m;
    logic                wr_en_w;
    logic                ld_e;
    logic                ld_m;
    logic                br_d;
    logic                br_taken_d;
    logic                jump_d;
    logic                md_d;
    logic [RAW-1:0]      md_dst_d;
    logic                halt_req;
    logic [NSRC*2-1:0]   fwd_e;
    logic [NSRC-1:0]     fwd_d;
    logic                stall_f;
    logic                stall_d;
    logic                flush_d;
    logic                flush_e;
    logic                md_wb;
    logic                halted;
    logic [SCW-1:0]      stall_cnt;

    modport master (
        output src_d, src_e, wr_reg_e, wr_reg_m, wr_reg_w,
        output wr_en_e, wr_en_m, wr_en_w, ld_e, ld_m,
        output br_d, br_taken_d, jump_d, md_d, md_dst_d, halt_req,
        input  fwd_e, fwd_d, stall_f, stall_d, flush_d, flush_e,
        input  md_wb, halted, stall_cnt
    );

    modport slave (
        input  src_d, src_e, wr_reg_e, wr_reg_m, wr_reg_w,
        input  wr_en_e, wr_en_m, wr_en_w, ld_e, ld_m,
        input  br_d, br_taken_d, jump_d, md_d, md_dst_d, halt_req,
        output fwd_e, fwd_d, stall_f, stall_d, flush_d, flush_e,
        output md_wb, halted, stall_cnt
    );

endinterface

// File: rtl/hs_scoreboard.sv
// MUL/DIV pending-register scoreboard and latency counter.
// Ports: clk, reset, issue, md_dst_d in; pending, md_busy, md_wb out.
module hs_scoreboard
    import hazard_pkg::*;
#(
    parameter int RAW    = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [RAW-1:0]    md_dst_d,
    output logic [2**RAW-1:0] pending,
    output logic              md_busy,
    output logic              md_wb
);

    localparam logic [3:0] LAT = 4'(MD_LAT);

    logic [3:0]         cnt;
    logic [RAW-1:0]     dst_q;
    logic [2**RAW-1:0]  pend_nxt;

    assign md_busy = (cnt != 4'd0);
    assign md_wb   = (cnt == 4'd1);

    // Clear before set so a same-register reissue on the
    // writeback cycle keeps the register pending.
    always_comb begin
        pend_nxt = pending;
        if (md_wb)
            pend_nxt[dst_q] = 1'b0;
        if (issue && (md_dst_d != '0))
            pend_nxt[md_dst_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            dst_q   <= '0;
            pending <= '0;
        end else begin
            pending <= pend_nxt;
            if (issue) begin
                cnt   <= LAT;
                dst_q <= md_dst_d;
            end else if (md_busy) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// 5-stage hazard unit: forwarding, stalls, flushes, MUL/DIV scoreboard,
// halt/drain FSM, stall counter. Ports: clk, reset, bus (slave).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int RAW    = 5,
    parameter int NSRC   = 2,
    parameter int MD_LAT = 4,
    parameter int SCW    = 32
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);

    logic [2**RAW-1:0] pending;
    logic              md_busy;
    logic              md_wb;
    logic              stall;
    logic              issue;
    hs_state_e         state;
    hs_state_e         state_nxt;
    logic [1:0]        dcnt;
    logic [SCW-1:0]    scnt;

    hs_scoreboard #(
        .RAW    (RAW),
        .MD_LAT (MD_LAT)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .md_dst_d (bus.md_dst_d),
        .pending  (pending),
        .md_busy  (md_busy),
        .md_wb    (md_wb)
    );

    always_comb begin
        logic [RAW-1:0] se;
        logic [RAW-1:0] sd;
        bus.fwd_e = '0;
        bus.fwd_d = '0;
        for (int k = 0; k < NSRC; k++) begin
            se = bus.src_e[k*RAW +: RAW];
            sd = bus.src_d[k*RAW +: RAW];
            if (se != '0 && se == bus.wr_reg_m && bus.wr_en_m)
                bus.fwd_e[k*2 +: 2] = FWD_M;
            else if (se != '0 && se == bus.wr_reg_w && bus.wr_en_w)
                bus.fwd_e[k*2 +: 2] = FWD_W;
            else
                bus.fwd_e[k*2 +: 2] = FWD_RF;
            bus.fwd_d[k] = (sd != '0) && (sd == bus.wr_reg_m)
                         && bus.wr_en_m && !bus.ld_m;
        end
    end

    // The writeback cycle frees the unit, so a queued MUL/DIV may go.
    always_comb begin
        logic [RAW-1:0] s;
        stall = bus.md_d && md_busy && !md_wb;
        for (int k = 0; k < NSRC; k++) begin
            s = bus.src_d[k*RAW +: RAW];
            if (s != '0) begin
                if (bus.ld_e && bus.wr_en_e && s == bus.wr_reg_e)
                    stall = 1'b1;
                if (bus.br_d && bus.wr_en_e && s == bus.wr_reg_e)
                    stall = 1'b1;
                if (bus.br_d && bus.ld_m && s == bus.wr_reg_m)
                    stall = 1'b1;
                if (pending[s])
                    stall = 1'b1;
            end
        end
    end

    assign issue        = bus.md_d && !stall && (state == RUN);
    assign bus.stall_f  = stall || (state != RUN);
    assign bus.stall_d  = stall || (state == HALTED);
    assign bus.flush_e  = stall;
    assign bus.flush_d  = (state == DRAIN) ||
                          ((bus.jump_d || (bus.br_d && bus.br_taken_d))
                           && !bus.stall_d);
    assign bus.md_wb    = md_wb;
    assign bus.halted   = (state == HALTED);
    assign bus.stall_cnt = scnt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (bus.halt_req)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!bus.halt_req)
                    state_nxt = RUN;
                else if (dcnt == 2'd2 && !md_busy)
                    state_nxt = HALTED;
            end
            HALTED: begin
                if (!bus.halt_req)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // dcnt == 2 marks the third DRAIN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            dcnt  <= 2'd0;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state != DRAIN)
                dcnt <= 2'd0;
            else if (dcnt != 2'd2)
                dcnt <= dcnt + 2'd1;
            if (bus.stall_d && scnt != '1)
                scnt <= scnt + SCW'(1);
        end
    end

endmodule
